mem_1rw_client_ctrl: RTL

Requester-side controller for the single-port, masked-write hard memory wrappers. It accepts read/write requests on a valid/ready interface and drives the wrapper's valid, write, address, data and bit-mask pins, expanding byte masks to bit masks. Read data is captured after the memory's one-cycle latency into a 2-entry response buffer with a valid/yumi handshake. After reset it can optionally zero-fill the whole array before accepting traffic. It sits between a cache/TLB pipeline stage and the memory wrapper.

---
 rtl/mem_1rw_client_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_1rw_client_ctrl.sv
// Requester-side controller for a single-port masked-write memory wrapper:
// optional zero-fill sweep after reset, credit-limited reads, 2-entry response buffer.
module mem_1rw_client_ctrl #(
  parameter  int els_p         = 512,
  parameter  int width_p       = 64,
  parameter  int mask_width_p  = 8,
  parameter  int init_p        = 1,
  localparam int addr_width_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic                     v_i,
  output logic                     ready_o,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [mask_width_p-1:0]  mask_i,

  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i,

  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  output logic [width_p-1:0]       mem_w_mask_o,
  input  logic [width_p-1:0]       mem_data_i
);

  localparam int lane_width_lp = width_p / mask_width_p;
  localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

  typedef enum logic {INIT, READY} state_e;

  state_e                   state_r, state_n;
  logic [addr_width_lp-1:0] sweep_r, sweep_n;
  logic [1:0]               credits_r;
  logic                     pending_r;
  logic [width_p-1:0]       fifo_r [2];
  logic                     wr_ptr_r, rd_ptr_r;
  logic [1:0]               count_r;

  logic               ready;
  logic               accept;
  logic               read_acc;
  logic               push, pop;
  logic [width_p-1:0] mask_exp;

  // Reset forces the handshake and memory enables low even though INIT is already loaded.
  assign ready    = (state_r == READY) && (credits_r != 2'd0) && !reset_i;
  assign accept   = v_i & ready;
  assign read_acc = accept & ~w_i;
  assign ready_o  = ready;

  always_comb begin
    mask_exp = '0;
    for (int unsigned k = 0; k < mask_width_p; k++) begin
      mask_exp[k*lane_width_lp +: lane_width_lp] = {lane_width_lp{mask_i[k]}};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= (init_p != 0) ? INIT : READY;
      sweep_r <= '0;
    end else begin
      state_r <= state_n;
      sweep_r <= sweep_n;
    end
  end

  always_comb begin
    state_n      = state_r;
    sweep_n      = sweep_r;
    mem_v_o      = 1'b0;
    mem_w_o      = 1'b0;
    mem_addr_o   = addr_i;
    mem_data_o   = data_i;
    mem_w_mask_o = mask_exp;
    case (state_r)
      INIT: begin
        mem_v_o      = !reset_i;
        mem_w_o      = !reset_i;
        mem_addr_o   = sweep_r;
        mem_data_o   = '0;
        mem_w_mask_o = '1;
        sweep_n      = sweep_r + 1'b1;
        if (sweep_r == last_addr_lp) begin
          state_n = READY;
          sweep_n = '0;
        end
      end
      READY: begin
        mem_v_o = accept;
        mem_w_o = accept & w_i;
      end
      default: state_n = READY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      credits_r <= 2'd2;
      pending_r <= 1'b0;
    end else begin
      credits_r <= credits_r + {1'b0, yumi_i} - {1'b0, read_acc};
      pending_r <= read_acc;
    end
  end

  assign push   = pending_r;
  assign pop    = yumi_i & v_o;
  assign v_o    = (count_r != 2'd0);
  assign data_o = fifo_r[rd_ptr_r];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= ~wr_ptr_r;
      if (pop)  rd_ptr_r <= ~rd_ptr_r;
      count_r <= count_r + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_r[wr_ptr_r] <= mem_data_i;
  end

endmodule
